// File: rtl/arb_resp_pkg.sv
// Shared helpers for the arbitration response tracker: width derivations
// used by the top and by the ID FIFO so both agree on index/count sizes.
package arb_resp_pkg;

    // Width of a winner index; a single input still needs one bit.
    function automatic int idx_width(input int num_in);
        return (num_in > 1) ? $clog2(num_in) : 1;
    endfunction

    // Width of an occupancy counter able to hold 0..max_out inclusive.
    function automatic int cnt_width(input int max_out);
        return $clog2(max_out + 1);
    endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// In-order FIFO of winner indices. One entry per accepted request; the
// head names the input that owns the next slave response. Pointers wrap
// at Depth, so non-power-of-two depths work. The fill level is the
// outstanding-transaction count.
module arb_id_fifo
    import arb_resp_pkg::*;
#(
    parameter int Depth = 4,
    parameter int Width = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int CntWidth = cnt_width(Depth);
    localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0]    mem_q [Depth];
    logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0] level_q, level_d;
    logic                do_push, do_pop;

    function automatic logic [PtrWidth-1:0] ptr_next(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (level_q == CntWidth'(Depth));
    assign empty_o = (level_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    // Next pointers and level; flush discards every entry.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_next(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_next(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + CntWidth'(1);
                2'b01:   level_d = level_q - CntWidth'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Pointer/level state and entry storage.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/arb_resp_tracker.sv
// Sits behind the round-robin arbitration tree: registers the arbitrated
// request towards one shared slave port and remembers each winner index so
// the slave's in-order responses are steered back to the right input.
//
// Handshakes: every channel transfers on a cycle where valid & ready are
// both high. A valid, once raised, holds its payload until that transfer;
// ready outputs never look at the matching valid input.
module arb_resp_tracker
    import arb_resp_pkg::*;
#(
    parameter int NumIn          = 4,
    parameter int DataWidth      = 32,
    parameter int RespWidth      = 32,
    parameter int MaxOutstanding = 4,
    parameter int IdxWidth       = idx_width(NumIn)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [DataWidth-1:0] req_data_i,
    input  logic [IdxWidth-1:0]  req_idx_i,
    output logic                 slv_valid_o,
    input  logic                 slv_ready_i,
    output logic [DataWidth-1:0] slv_data_o,
    input  logic                 rsp_valid_i,
    output logic                 rsp_ready_o,
    input  logic [RespWidth-1:0] rsp_data_i,
    output logic [NumIn-1:0]     rsp_valid_o,
    input  logic [NumIn-1:0]     rsp_ready_i,
    output logic [RespWidth-1:0] rsp_data_o
);

    logic                 slv_valid_q, slv_valid_d;
    logic [DataWidth-1:0] slv_data_q, slv_data_d;
    logic                 id_full, id_empty;
    logic                 push, pop;
    logic [IdxWidth-1:0]  push_idx, fifo_head, head_idx;
    logic                 head_ready;

    // Acceptance only depends on FIFO room and the register draining, so
    // the response handshake never feeds back into the arbiter grant.
    assign req_ready_o = ~rst_i & ~flush_i & ~id_full & (~slv_valid_q | slv_ready_i);
    assign push        = req_valid_i & req_ready_o;
    assign pop         = rsp_valid_i & rsp_ready_o;
    assign slv_valid_o = slv_valid_q;
    assign slv_data_o  = slv_data_q;
    assign rsp_data_o  = rsp_data_i;

    // With a single input there is nothing to route; the FIFO only counts.
    if (NumIn > 1) begin : g_idx
        assign push_idx = req_idx_i;
        assign head_idx = fifo_head;
    end else begin : g_idx_tied
        assign push_idx = '0;
        assign head_idx = '0;
    end

    // Request register: load on accept, hold while stalled, drain on slave ready.
    always_comb begin
        slv_valid_d = slv_valid_q;
        slv_data_d  = slv_data_q;
        if (flush_i) begin
            slv_valid_d = 1'b0;
            slv_data_d  = '0;
        end else if (push) begin
            slv_valid_d = 1'b1;
            slv_data_d  = req_data_i;
        end else if (slv_ready_i) begin
            slv_valid_d = 1'b0;
        end
    end

    // Request register state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slv_valid_q <= 1'b0;
            slv_data_q  <= '0;
        end else begin
            slv_valid_q <= slv_valid_d;
            slv_data_q  <= slv_data_d;
        end
    end

    // Steer the response valid to the head owner and pick up its ready.
    always_comb begin
        rsp_valid_o = '0;
        head_ready  = 1'b0;
        for (int i = 0; i < NumIn; i++) begin
            if (head_idx == IdxWidth'(i)) begin
                rsp_valid_o[i] = rsp_valid_i & ~id_empty;
                head_ready     = rsp_ready_i[i];
            end
        end
    end

    assign rsp_ready_o = ~flush_i & ~id_empty & head_ready;

    arb_id_fifo #(
        .Depth (MaxOutstanding),
        .Width (IdxWidth)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (push),
        .data_i  (push_idx),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .full_o  (id_full),
        .empty_o (id_empty)
    );

endmodule

// File: tb/tb_arb_resp_tracker.sv
// Bench for arb_resp_tracker: directed scenarios followed by a random soak.
// A negedge monitor holds a queue-level reference model (outstanding winner
// order, contents of the single request slot) and compares every output.
module tb_arb_resp_tracker;

    localparam int NUM_IN  = 4;
    localparam int DW      = 32;
    localparam int RW      = 32;
    localparam int MAX_OUT = 4;
    localparam int IW      = 2;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              flush_i;
    logic              req_valid_i;
    logic              req_ready_o;
    logic [DW-1:0]     req_data_i;
    logic [IW-1:0]     req_idx_i;
    logic              slv_valid_o;
    logic              slv_ready_i;
    logic [DW-1:0]     slv_data_o;
    logic              rsp_valid_i;
    logic              rsp_ready_o;
    logic [RW-1:0]     rsp_data_i;
    logic [NUM_IN-1:0] rsp_valid_o;
    logic [NUM_IN-1:0] rsp_ready_i;
    logic [RW-1:0]     rsp_data_o;

    // clock
    always #5 clk_i = ~clk_i;

    arb_resp_tracker #(
        .NumIn          (NUM_IN),
        .DataWidth      (DW),
        .RespWidth      (RW),
        .MaxOutstanding (MAX_OUT)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_data_i  (req_data_i),
        .req_idx_i   (req_idx_i),
        .slv_valid_o (slv_valid_o),
        .slv_ready_i (slv_ready_i),
        .slv_data_o  (slv_data_o),
        .rsp_valid_i (rsp_valid_i),
        .rsp_ready_o (rsp_ready_o),
        .rsp_data_i  (rsp_data_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_data_o  (rsp_data_o)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: winner order of outstanding requests, and the
    // payloads accepted but not yet taken by the slave.
    logic [IW-1:0] exp_q[$];
    logic [DW-1:0] slv_exp_q[$];
    int            slv_pend = 0;
    bit            last_acc = 0;
    bit            last_pop = 0;

    int                n_out;
    logic              reg_full, exp_ready, exp_rrdy, acc, pop, slv_hs;
    logic [IW-1:0]     head;
    logic [NUM_IN-1:0] exp_vld;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: compare every output against the model, then advance it.
    always @(negedge clk_i) begin
        if (rst_i) begin
            exp_q.delete();
            slv_exp_q.delete();
            slv_pend = 0;
            last_acc = 0;
            last_pop = 0;
        end else begin
            n_out    = exp_q.size();
            reg_full = (slv_exp_q.size() != 0);
            head     = '0;
            if (n_out > 0) head = exp_q[0];
            exp_ready = !flush_i && (n_out < MAX_OUT) && (!reg_full || slv_ready_i);
            exp_vld   = '0;
            if (rsp_valid_i && n_out > 0) exp_vld[head] = 1'b1;
            exp_rrdy  = !flush_i && (n_out > 0) && rsp_ready_i[head];

            chk("level", 64'(dut.u_id_fifo.level_q), 64'(n_out));
            chk("req_ready", req_ready_o, exp_ready);
            chk("slv_valid", slv_valid_o, reg_full);
            if (reg_full) chk("slv_data", slv_data_o, slv_exp_q[0]);
            chk("rsp_valid", rsp_valid_o, exp_vld);
            chk("rsp_onehot0", $onehot0(rsp_valid_o), 1);
            chk("rsp_ready", rsp_ready_o, exp_rrdy);
            chk("rsp_data", rsp_data_o, rsp_data_i);

            acc    = req_valid_i && exp_ready;
            pop    = rsp_valid_i && exp_rrdy;
            slv_hs = reg_full && slv_ready_i;
            last_acc = acc;
            last_pop = pop;
            if (flush_i) begin
                exp_q.delete();
                slv_exp_q.delete();
                slv_pend = 0;
            end else begin
                if (slv_hs) begin
                    void'(slv_exp_q.pop_front());
                    slv_pend++;
                end
                if (pop) begin
                    void'(exp_q.pop_front());
                    slv_pend--;
                end
                if (acc) begin
                    slv_exp_q.push_back(req_data_i);
                    exp_q.push_back(req_idx_i);
                end
            end
        end
    end

    logic [NUM_IN-1:0] ord_exp [3];
    logic [IW-1:0]     ord_idx [3];
    logic [DW-1:0]     bp_x;
    logic [IW-1:0]     bp_ix;
    logic [NUM_IN-1:0] mask;

    initial begin
        ord_exp = '{4'b1000, 4'b0001, 4'b0010};
        ord_idx = '{2'd3, 2'd0, 2'd1};

        // reset state
        rst_i = 1'b1; flush_i = 1'b0; req_valid_i = 1'b0; req_data_i = '0; req_idx_i = '0;
        slv_ready_i = 1'b1; rsp_valid_i = 1'b1; rsp_data_i = '0; rsp_ready_i = '1;
        step(); step();
        chk("init_req_ready", req_ready_o, 0);
        chk("init_slv_valid", slv_valid_o, 0);
        chk("init_slv_data", slv_data_o, 0);
        chk("init_rsp_valid", rsp_valid_o, 0);
        chk("init_rsp_ready", rsp_ready_o, 0);
        rst_i = 1'b0; rsp_valid_i = 1'b0;
        step();

        // single transaction
        req_valid_i = 1'b1; req_idx_i = 2'd2; req_data_i = 32'hA5A5_0001;
        step();
        req_valid_i = 1'b0;
        chk("single_slv_valid", slv_valid_o, 1);
        chk("single_slv_data", slv_data_o, 32'hA5A5_0001);
        step();
        step();
        rsp_valid_i = 1'b1; rsp_data_i = 32'h1234;
        #1;
        chk("single_rsp_valid", rsp_valid_o, 4'b0100);
        chk("single_rsp_data", rsp_data_o, 32'h1234);
        step();
        rsp_valid_i = 1'b0;
        chk("single_level", 64'(dut.u_id_fifo.level_q), 0);

        // ordering
        for (int i = 0; i < 3; i++) begin
            req_valid_i = 1'b1; req_idx_i = ord_idx[i]; req_data_i = $urandom;
            step();
        end
        req_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rsp_valid_i = 1'b1; rsp_data_i = $urandom;
            #1;
            chk("order_rsp_valid", rsp_valid_o, ord_exp[i]);
            step();
        end
        rsp_valid_i = 1'b0;

        // full
        for (int i = 0; i < MAX_OUT; i++) begin
            req_valid_i = 1'b1; req_idx_i = IW'($urandom_range(0, 3)); req_data_i = $urandom;
            step();
        end
        req_data_i = $urandom;
        chk("full_req_ready", req_ready_o, 0);
        step();
        rsp_valid_i = 1'b1;
        #1;
        chk("full_pop_no_push", req_ready_o, 0);
        step();
        rsp_valid_i = 1'b0;
        chk("full_accept_next", req_ready_o, 1);
        step();
        req_valid_i = 1'b0;
        for (int i = 0; i < MAX_OUT; i++) begin
            rsp_valid_i = 1'b1; rsp_data_i = $urandom;
            step();
        end
        rsp_valid_i = 1'b0;

        // back-pressure
        bp_x = $urandom; bp_ix = IW'($urandom_range(0, 3));
        slv_ready_i = 1'b0; req_valid_i = 1'b1; req_data_i = bp_x; req_idx_i = bp_ix;
        step();
        req_data_i = $urandom; req_idx_i = IW'($urandom_range(0, 3));
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_req_ready", req_ready_o, 0);
            chk("bp_slv_data", slv_data_o, bp_x);
            step();
        end
        slv_ready_i = 1'b1;
        step();
        req_valid_i = 1'b0;
        step();
        mask = 4'b0001 << bp_ix;
        rsp_ready_i = ~mask; rsp_valid_i = 1'b1; rsp_data_i = $urandom;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("bp_rsp_ready", rsp_ready_o, 0);
            step();
        end
        rsp_ready_i = '1;
        #1;
        chk("bp_rsp_ready_go", rsp_ready_o, 1);
        step();
        step();
        rsp_valid_i = 1'b0;

        // flush with the request slot occupied
        slv_ready_i = 1'b0; req_valid_i = 1'b1; req_data_i = $urandom; req_idx_i = 2'd1;
        step();
        req_valid_i = 1'b0; slv_ready_i = 1'b1; flush_i = 1'b1;
        #1;
        chk("flush_req_ready", req_ready_o, 0);
        chk("flush_rsp_ready", rsp_ready_o, 0);
        step();
        flush_i = 1'b0;
        chk("flush_slv_valid", slv_valid_o, 0);
        chk("flush_level", 64'(dut.u_id_fifo.level_q), 0);

        // reset mid-transfer with two outstanding
        req_valid_i = 1'b1; req_data_i = $urandom; req_idx_i = 2'd0;
        step();
        req_data_i = $urandom; req_idx_i = 2'd3;
        step();
        req_valid_i = 1'b0; slv_ready_i = 1'b0; rsp_valid_i = 1'b1; rsp_data_i = $urandom;
        #2;
        rst_i = 1'b1;
        #1;
        chk("rst_req_ready", req_ready_o, 0);
        chk("rst_slv_valid", slv_valid_o, 0);
        chk("rst_slv_data", slv_data_o, 0);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_rsp_ready", rsp_ready_o, 0);
        step();
        rst_i = 1'b0; rsp_valid_i = 1'b0; slv_ready_i = 1'b1;
        #1;
        chk("rst_level", 64'(dut.u_id_fifo.level_q), 0);
        step();

        // random soak
        for (int c = 0; c < 3000; c++) begin
            if (!req_valid_i || last_acc) begin
                req_valid_i = ($urandom_range(0, 3) != 0);
                req_idx_i   = IW'($urandom_range(0, 3));
                req_data_i  = $urandom;
            end
            slv_ready_i = ($urandom_range(0, 3) != 0);
            if (!rsp_valid_i || last_pop) begin
                rsp_valid_i = (slv_pend > 0) && ($urandom_range(0, 2) != 0);
                rsp_data_i  = $urandom;
            end
            rsp_ready_i = NUM_IN'($urandom_range(0, 15));
            step();
        end

        // drain, bounded
        req_valid_i = 1'b0; slv_ready_i = 1'b1; rsp_ready_i = '1;
        for (int c = 0; c < 200 && exp_q.size() > 0; c++) begin
            rsp_valid_i = (slv_pend > 0);
            rsp_data_i  = $urandom;
            step();
        end
        rsp_valid_i = 1'b0;
        step();
        chk("drain_timeout", 64'(exp_q.size()), 0);
        chk("drain_level", 64'(dut.u_id_fifo.level_q), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
